// File: rtl/mem_arbiter_if.sv
// -----------------------------------------------------------------------------
// mem_arbiter_if
//   Bundles the core-side and memory-side handshake of mem_arbiter.
//
//   Core side (one lane per port, packed):
//     req_request   - per-port request, held until that port's response
//     req_wren      - per-port write enable (1 = write)
//     req_address   - packed addresses, port i at [i*WIDTH +: WIDTH]
//     req_writedata - packed write data, same packing
//     req_response  - one-cycle completion pulse per port
//     req_readdata  - shared read data, valid while a response bit is high
//   Memory side:
//     mem_request, mem_wren, mem_address, mem_writedata (to memory)
//     mem_readdata, mem_response (from memory)
//   Status:
//     grant_id      - index of the current or last granted port
//     timeout_err   - one-cycle pulse when a transaction is aborted
//
//   Modports: master = the arbiter, slave = cores plus memory.
// -----------------------------------------------------------------------------
interface mem_arbiter_if #(
  parameter int WIDTH     = 32,
  parameter int N_PORTS   = 4,
  parameter int PORT_BITS = 2
) ();

  logic [N_PORTS-1:0]       req_request;
  logic [N_PORTS-1:0]       req_wren;
  logic [N_PORTS*WIDTH-1:0] req_address;
  logic [N_PORTS*WIDTH-1:0] req_writedata;
  logic [N_PORTS-1:0]       req_response;
  logic [WIDTH-1:0]         req_readdata;

  logic                     mem_request;
  logic                     mem_wren;
  logic [WIDTH-1:0]         mem_address;
  logic [WIDTH-1:0]         mem_writedata;
  logic [WIDTH-1:0]         mem_readdata;
  logic                     mem_response;

  logic [PORT_BITS-1:0]     grant_id;
  logic                     timeout_err;

  modport master (
    input  req_request, req_wren, req_address, req_writedata,
    input  mem_readdata, mem_response,
    output req_response, req_readdata,
    output mem_request, mem_wren, mem_address, mem_writedata,
    output grant_id, timeout_err
  );

  modport slave (
    output req_request, req_wren, req_address, req_writedata,
    output mem_readdata, mem_response,
    input  req_response, req_readdata,
    input  mem_request, mem_wren, mem_address, mem_writedata,
    input  grant_id, timeout_err
  );

endinterface : mem_arbiter_if

// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
//   Shares one memory port between N_PORTS cores. Round-robin arbitration,
//   one outstanding transaction at a time, with a response timeout so a dead
//   memory cannot hang a core.
//
//   Flow per transaction: IDLE (arbitrate, latch) -> BUSY (wait for
//   mem_response or timeout) -> DONE (one-cycle response pulse) -> IDLE.
//
//   Ports:
//     clk   - clock
//     reset - synchronous active-high reset
//     bus   - mem_arbiter_if.master, all handshake/bus signals
// -----------------------------------------------------------------------------
module mem_arbiter #(
  parameter int WIDTH     = 32,
  parameter int N_PORTS   = 4,
  parameter int PORT_BITS = 2,
  parameter int TIMEOUT   = 255
) (
  input  logic           clk,
  input  logic           reset,
  mem_arbiter_if.master  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int CNT_BITS = (TIMEOUT <= 255) ? 8 : $clog2(TIMEOUT + 1);
  localparam logic [PORT_BITS-1:0] LAST_PORT = PORT_BITS'(N_PORTS - 1);
  // The abort fires on the BUSY cycle whose increment would reach TIMEOUT,
  // so a transaction spends exactly TIMEOUT cycles in BUSY before aborting.
  localparam logic [CNT_BITS-1:0] TIMEOUT_M1 =
    CNT_BITS'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

  state_e               state_q, state_d;
  logic [PORT_BITS-1:0] last_q, last_d;
  logic [PORT_BITS-1:0] grant_q, grant_d;
  logic [CNT_BITS-1:0]  cnt_q, cnt_d;
  logic                 mem_request_q, mem_request_d;
  logic                 mem_wren_q, mem_wren_d;
  logic [WIDTH-1:0]     mem_address_q, mem_address_d;
  logic [WIDTH-1:0]     mem_writedata_q, mem_writedata_d;
  logic [N_PORTS-1:0]   req_response_q, req_response_d;
  logic [WIDTH-1:0]     req_readdata_q, req_readdata_d;
  logic                 timeout_err_q, timeout_err_d;

  logic                 any_req;
  logic [PORT_BITS-1:0] sel_idx;
  logic [PORT_BITS-1:0] cand;

  // Explicit wrap so non-power-of-2 port counts rotate correctly.
  function automatic logic [PORT_BITS-1:0] wrap_inc(input logic [PORT_BITS-1:0] p);
    return (p == LAST_PORT) ? '0 : p + 1'b1;
  endfunction

  // Round-robin pick: first set request scanning last+1, last+2, ... so the
  // port served most recently is considered last.
  always_comb begin
    any_req = 1'b0;
    sel_idx = '0;
    cand    = last_q;
    for (int i = 0; i < N_PORTS; i++) begin
      cand = wrap_inc(cand);
      if (!any_req && bus.req_request[cand]) begin
        any_req = 1'b1;
        sel_idx = cand;
      end
    end
  end

  // NOTE: every variable gets a default before the case statement; a path
  // that leaves one unassigned would infer a latch.
  always_comb begin
    state_d         = state_q;
    last_d          = last_q;
    grant_d         = grant_q;
    cnt_d           = cnt_q;
    mem_request_d   = mem_request_q;
    mem_wren_d      = mem_wren_q;
    mem_address_d   = mem_address_q;
    mem_writedata_d = mem_writedata_q;
    req_readdata_d  = req_readdata_q;
    req_response_d  = '0;
    timeout_err_d   = 1'b0;

    unique case (state_q)
      IDLE: begin
        // mem_response while idle is deliberately ignored.
        if (any_req) begin
          grant_d         = sel_idx;
          last_d          = sel_idx;
          mem_wren_d      = bus.req_wren[sel_idx];
          mem_address_d   = bus.req_address[sel_idx*WIDTH +: WIDTH];
          mem_writedata_d = bus.req_writedata[sel_idx*WIDTH +: WIDTH];
          mem_request_d   = 1'b1;
          cnt_d           = '0;
          state_d         = BUSY;
        end
      end

      BUSY: begin
        // Response is tested first so it wins over a simultaneous timeout.
        if (bus.mem_response) begin
          req_readdata_d          = bus.mem_readdata;
          req_response_d[grant_q] = 1'b1;
          mem_request_d           = 1'b0;
          cnt_d                   = '0;
          state_d                 = DONE;
        end else if (TIMEOUT != 0 && cnt_q == TIMEOUT_M1) begin
          req_readdata_d          = '0;
          req_response_d[grant_q] = 1'b1;
          timeout_err_d           = 1'b1;
          mem_request_d           = 1'b0;
          cnt_d                   = '0;
          state_d                 = DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      // No arbitration here: the finishing port drops its request on this
      // edge, so arbitrating now would re-grant it on a stale request.
      DONE: state_d = IDLE;

      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= IDLE;
      last_q          <= LAST_PORT;
      grant_q         <= '0;
      cnt_q           <= '0;
      mem_request_q   <= 1'b0;
      mem_wren_q      <= 1'b0;
      mem_address_q   <= '0;
      mem_writedata_q <= '0;
      req_response_q  <= '0;
      req_readdata_q  <= '0;
      timeout_err_q   <= 1'b0;
    end else begin
      state_q         <= state_d;
      last_q          <= last_d;
      grant_q         <= grant_d;
      cnt_q           <= cnt_d;
      mem_request_q   <= mem_request_d;
      mem_wren_q      <= mem_wren_d;
      mem_address_q   <= mem_address_d;
      mem_writedata_q <= mem_writedata_d;
      req_response_q  <= req_response_d;
      req_readdata_q  <= req_readdata_d;
      timeout_err_q   <= timeout_err_d;
    end
  end

  assign bus.mem_request   = mem_request_q;
  assign bus.mem_wren      = mem_wren_q;
  assign bus.mem_address   = mem_address_q;
  assign bus.mem_writedata = mem_writedata_q;
  assign bus.req_response  = req_response_q;
  assign bus.req_readdata  = req_readdata_q;
  assign bus.grant_id      = grant_q;
  assign bus.timeout_err   = timeout_err_q;

endmodule : mem_arbiter

// File: tb/tb_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_arbiter
//   Directed bench for mem_arbiter (N_PORTS=4, WIDTH=32, TIMEOUT=5).
//   Inputs change and outputs are sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_mem_arbiter;

  localparam int W = 32;
  localparam int N = 4;

  logic clk;
  logic reset;
  int   n_asserts;
  int   n_fail;

  mem_arbiter_if #(.WIDTH(W), .N_PORTS(N), .PORT_BITS(2)) bus ();

  mem_arbiter #(
    .WIDTH(W), .N_PORTS(N), .PORT_BITS(2), .TIMEOUT(5)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic set_port(input int p, input logic req, input logic wren,
                          input logic [31:0] addr, input logic [31:0] data);
    bus.req_request[p]          = req;
    bus.req_wren[p]             = wren;
    bus.req_address[p*W +: W]   = addr;
    bus.req_writedata[p*W +: W] = data;
  endtask

  task automatic clear_inputs();
    bus.req_request   = '0;
    bus.req_wren      = '0;
    bus.req_address   = '0;
    bus.req_writedata = '0;
    bus.mem_response  = 1'b0;
    bus.mem_readdata  = '0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    clear_inputs();
    tick();
    tick();
    reset = 1'b0;
  endtask

  initial begin
    logic [1:0] exp_g;
    n_asserts = 0;
    n_fail    = 0;
    reset     = 1'b1;
    clear_inputs();
    tick();
    tick();

    // Reset state
    check("rst_mem_request",  32'(bus.mem_request), 32'h0);
    check("rst_req_response", 32'(bus.req_response), 32'h0);
    check("rst_grant_id",     32'(bus.grant_id), 32'h0);
    check("rst_timeout_err",  32'(bus.timeout_err), 32'h0);
    check("rst_req_readdata", bus.req_readdata, 32'h0);
    check("rst_mem_address",  bus.mem_address, 32'h0);

    // 1: single read on port 0, memory answers on the 3rd BUSY cycle
    reset = 1'b0;
    set_port(0, 1'b1, 1'b0, 32'h10, 32'h0);
    tick();
    check("t1_busy1_mem_request", 32'(bus.mem_request), 32'h1);
    check("t1_mem_address",       bus.mem_address, 32'h10);
    check("t1_mem_wren",          32'(bus.mem_wren), 32'h0);
    check("t1_grant_id",          32'(bus.grant_id), 32'h0);
    tick();
    check("t1_busy2_mem_request", 32'(bus.mem_request), 32'h1);
    check("t1_busy2_response",    32'(bus.req_response), 32'h0);
    tick();
    check("t1_busy3_mem_request", 32'(bus.mem_request), 32'h1);
    bus.mem_response = 1'b1;
    bus.mem_readdata = 32'hDEADBEEF;
    tick();
    bus.mem_response = 1'b0;
    bus.mem_readdata = 32'h0;
    set_port(0, 1'b0, 1'b0, 32'h10, 32'h0);
    check("t1_done_response",    32'(bus.req_response), 32'h1);
    check("t1_done_readdata",    bus.req_readdata, 32'hDEADBEEF);
    check("t1_done_mem_request", 32'(bus.mem_request), 32'h0);
    check("t1_done_timeout_err", 32'(bus.timeout_err), 32'h0);
    tick();
    check("t1_idle_response", 32'(bus.req_response), 32'h0);
    check("t1_idle_readdata", bus.req_readdata, 32'hDEADBEEF);

    // 2: all ports request continuously, immediate memory answers
    do_reset();
    for (int p = 0; p < N; p++) set_port(p, 1'b1, 1'b0, 32'h100 + 32'(p) * 4, 32'h0);
    for (int k = 0; k < 5; k++) begin
      exp_g = 2'(k % N);
      tick();
      check("t2_busy_mem_request", 32'(bus.mem_request), 32'h1);
      check("t2_grant_id",         32'(bus.grant_id), 32'(exp_g));
      check("t2_mem_address",      bus.mem_address, 32'h100 + 32'(exp_g) * 4);
      check("t2_busy_no_response", 32'(bus.req_response), 32'h0);
      bus.mem_response = 1'b1;
      bus.mem_readdata = 32'hA000_0000 + 32'(k);
      tick();
      bus.mem_response = 1'b0;
      check("t2_done_response",   32'(bus.req_response), 32'h1 << exp_g);
      check("t2_done_onehot",     32'($countones(bus.req_response) <= 1), 32'h1);
      check("t2_done_readdata",   bus.req_readdata, 32'hA000_0000 + 32'(k));
      tick();
      check("t2_idle_mem_request", 32'(bus.mem_request), 32'h0);
      check("t2_idle_response",    32'(bus.req_response), 32'h0);
    end
    bus.req_request = '0;

    // 3: port 2 write; port 1 arrives and changes its address while BUSY
    set_port(2, 1'b1, 1'b1, 32'h40, 32'h12345678);
    tick();
    check("t3_grant_id",      32'(bus.grant_id), 32'h2);
    check("t3_mem_wren",      32'(bus.mem_wren), 32'h1);
    check("t3_mem_address",   bus.mem_address, 32'h40);
    check("t3_mem_writedata", bus.mem_writedata, 32'h12345678);
    set_port(1, 1'b1, 1'b0, 32'h20, 32'h0);
    tick();
    check("t3_hold_address",   bus.mem_address, 32'h40);
    check("t3_hold_writedata", bus.mem_writedata, 32'h12345678);
    check("t3_hold_grant",     32'(bus.grant_id), 32'h2);
    set_port(1, 1'b1, 1'b0, 32'h24, 32'h0);
    tick();
    check("t3_hold2_address", bus.mem_address, 32'h40);
    check("t3_hold2_wren",    32'(bus.mem_wren), 32'h1);
    bus.mem_response = 1'b1;
    bus.mem_readdata = 32'h0;
    tick();
    bus.mem_response = 1'b0;
    check("t3_done_response", 32'(bus.req_response), 32'h4);
    set_port(2, 1'b0, 1'b0, 32'h0, 32'h0);
    tick();
    tick();
    check("t3_p1_grant_id",    32'(bus.grant_id), 32'h1);
    check("t3_p1_mem_address", bus.mem_address, 32'h24);
    check("t3_p1_mem_wren",    32'(bus.mem_wren), 32'h0);
    bus.mem_response = 1'b1;
    bus.mem_readdata = 32'h55;
    tick();
    bus.mem_response = 1'b0;
    check("t3_p1_response", 32'(bus.req_response), 32'h2);
    check("t3_p1_readdata", bus.req_readdata, 32'h55);
    set_port(1, 1'b0, 1'b0, 32'h0, 32'h0);
    tick();

    // 4: timeout on port 3, memory silent for the whole BUSY window
    set_port(3, 1'b1, 1'b0, 32'h30, 32'h0);
    bus.mem_readdata = 32'hBADBAD00;
    for (int c = 0; c < 5; c++) begin
      tick();
      check("t4_busy_mem_request", 32'(bus.mem_request), 32'h1);
      check("t4_busy_timeout_err", 32'(bus.timeout_err), 32'h0);
    end
    tick();
    check("t4_timeout_err",      32'(bus.timeout_err), 32'h1);
    check("t4_timeout_response", 32'(bus.req_response), 32'h8);
    check("t4_timeout_readdata", bus.req_readdata, 32'h0);
    check("t4_timeout_mem_req",  32'(bus.mem_request), 32'h0);
    set_port(3, 1'b0, 1'b0, 32'h0, 32'h0);
    tick();
    check("t4_after_err",      32'(bus.timeout_err), 32'h0);
    check("t4_after_response", 32'(bus.req_response), 32'h0);
    set_port(0, 1'b1, 1'b0, 32'h70, 32'h0);
    tick();
    check("t4_next_grant",   32'(bus.grant_id), 32'h0);
    check("t4_next_address", bus.mem_address, 32'h70);
    bus.mem_response = 1'b1;
    bus.mem_readdata = 32'h77;
    tick();
    bus.mem_response = 1'b0;
    check("t4_next_response", 32'(bus.req_response), 32'h1);
    check("t4_next_readdata", bus.req_readdata, 32'h77);
    check("t4_next_err",      32'(bus.timeout_err), 32'h0);
    set_port(0, 1'b0, 1'b0, 32'h0, 32'h0);
    tick();

    // 5: response on the same cycle the timeout would fire
    set_port(1, 1'b1, 1'b0, 32'h88, 32'h0);
    for (int c = 0; c < 4; c++) begin
      tick();
      check("t5_busy_mem_request", 32'(bus.mem_request), 32'h1);
    end
    tick();
    check("t5_last_busy_mem_request", 32'(bus.mem_request), 32'h1);
    bus.mem_response = 1'b1;
    bus.mem_readdata = 32'hCAFEF00D;
    tick();
    bus.mem_response = 1'b0;
    check("t5_response",    32'(bus.req_response), 32'h2);
    check("t5_readdata",    bus.req_readdata, 32'hCAFEF00D);
    check("t5_timeout_err", 32'(bus.timeout_err), 32'h0);
    set_port(1, 1'b0, 1'b0, 32'h0, 32'h0);
    tick();

    // 6: reset in the middle of BUSY, then port 3 alone
    set_port(2, 1'b1, 1'b0, 32'h90, 32'h0);
    tick();
    check("t6_busy_grant",       32'(bus.grant_id), 32'h2);
    check("t6_busy_mem_request", 32'(bus.mem_request), 32'h1);
    reset = 1'b1;
    tick();
    check("t6_rst_mem_request", 32'(bus.mem_request), 32'h0);
    check("t6_rst_response",    32'(bus.req_response), 32'h0);
    check("t6_rst_grant",       32'(bus.grant_id), 32'h0);
    reset = 1'b0;
    set_port(2, 1'b0, 1'b0, 32'h0, 32'h0);
    set_port(3, 1'b1, 1'b0, 32'h3C, 32'h0);
    tick();
    check("t6_no_stale_response", 32'(bus.req_response), 32'h0);
    check("t6_p3_grant",          32'(bus.grant_id), 32'h3);
    check("t6_p3_mem_address",    bus.mem_address, 32'h3C);
    bus.mem_response = 1'b1;
    bus.mem_readdata = 32'h33;
    tick();
    bus.mem_response = 1'b0;
    check("t6_p3_response", 32'(bus.req_response), 32'h8);
    check("t6_p3_readdata", bus.req_readdata, 32'h33);
    set_port(3, 1'b0, 1'b0, 32'h0, 32'h0);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule : tb_mem_arbiter
